// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: bundles every non-clock signal of the writeback arbiter.
//   pipeline writeback : pipe_we / pipe_wa / pipe_wd
//   long-unit results  : lu_valid / lu_ready / lu_wa / lu_wd
//   scoreboard / decode: sb_set / sb_set_addr / ra1 / ra2 / rs1_busy / rs2_busy
//   operand read path  : rf_rd1 / rf_rd2 / rd1_out / rd2_out
//   register-file write: rf_we / rf_wa / rf_wd
//   status             : stall_req / fifo_count
// The master modport is the arbiter itself, which drives the register-file write port.
// The slave modport is the surrounding pipeline, register file and long unit.
interface wb_arbiter_if #(
    parameter int unsigned FIFO_DEPTH = 4
);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic              pipe_we;
    logic [4:0]        pipe_wa;
    logic [31:0]       pipe_wd;
    logic              lu_valid;
    logic              lu_ready;
    logic [4:0]        lu_wa;
    logic [31:0]       lu_wd;
    logic              sb_set;
    logic [4:0]        sb_set_addr;
    logic [4:0]        ra1;
    logic [4:0]        ra2;
    logic              rs1_busy;
    logic              rs2_busy;
    logic [31:0]       rf_rd1;
    logic [31:0]       rf_rd2;
    logic [31:0]       rd1_out;
    logic [31:0]       rd2_out;
    logic              rf_we;
    logic [4:0]        rf_wa;
    logic [31:0]       rf_wd;
    logic              stall_req;
    logic [CNT_W-1:0]  fifo_count;

    modport master (
        input  pipe_we, pipe_wa, pipe_wd,
        input  lu_valid, lu_wa, lu_wd,
        output lu_ready,
        input  sb_set, sb_set_addr, ra1, ra2,
        output rs1_busy, rs2_busy,
        input  rf_rd1, rf_rd2,
        output rd1_out, rd2_out,
        output rf_we, rf_wa, rf_wd,
        output stall_req, fifo_count
    );

    modport slave (
        output pipe_we, pipe_wa, pipe_wd,
        output lu_valid, lu_wa, lu_wd,
        input  lu_ready,
        output sb_set, sb_set_addr, ra1, ra2,
        input  rs1_busy, rs2_busy,
        output rf_rd1, rf_rd2,
        input  rd1_out, rd2_out,
        input  rf_we, rf_wa, rf_wd,
        input  stall_req, fifo_count
    );
endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback stage that owns the single register-file write port.
// Merges in-order pipeline writeback (always wins) with long-unit results buffered
// in a FIFO, keeps a per-register pending scoreboard for decode, and raises
// stall_req when buffered results have been starved for STARVE_LIMIT cycles.
// Ports: clk, rst_n (async active-low) and the wb_arbiter_if.master bundle.
// Optional feature macro WB_BYPASS_EN: forwards the register-file write landing
// this edge onto rd1_out/rd2_out; otherwise the operands pass straight through.
module wb_arbiter #(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    wb_arbiter_if.master bus
);
    localparam int unsigned AW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CW   = AW + 1;
    localparam int unsigned SW   = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned RW   = 5;
    localparam int unsigned DW   = 32;
    localparam int unsigned NREG = 32;

    logic [RW-1:0]   fifo_wa_q [FIFO_DEPTH];
    logic [RW-1:0]   fifo_wa_d [FIFO_DEPTH];
    logic [DW-1:0]   fifo_wd_q [FIFO_DEPTH];
    logic [DW-1:0]   fifo_wd_d [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [NREG-1:0] pending_q, pending_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic            stall_req_q, stall_req_d;
    logic            rf_we_q, rf_we_d;
    logic [RW-1:0]   rf_wa_q, rf_wa_d;
    logic [DW-1:0]   rf_wd_q, rf_wd_d;

    logic            fifo_empty_c;
    logic            lu_ready_c;
    logic            push_c;
    logic            pop_c;
    logic            pipe_win_c;
    logic [RW-1:0]   head_wa_c;
    logic [DW-1:0]   head_wd_c;

    // Handshake and arbitration decisions; pipeline writes to x0 count as idle.
    always_comb begin
        fifo_empty_c = (count_q == CW'(0));
        lu_ready_c   = (count_q != CW'(FIFO_DEPTH));
        push_c       = bus.lu_valid && lu_ready_c;
        pipe_win_c   = bus.pipe_we && (bus.pipe_wa != RW'(0));
        // Only entries present before this edge are poppable: no fall-through.
        pop_c        = !pipe_win_c && !fifo_empty_c;
        head_wa_c    = fifo_wa_q[rd_ptr_q];
        head_wd_c    = fifo_wd_q[rd_ptr_q];
    end

    // FIFO storage, pointers and occupancy.
    always_comb begin
        fifo_wa_d = fifo_wa_q;
        fifo_wd_d = fifo_wd_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (push_c) begin
            fifo_wa_d[wr_ptr_q] = bus.lu_wa;
            fifo_wd_d[wr_ptr_q] = bus.lu_wd;
            wr_ptr_d            = wr_ptr_q + AW'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Register-file write port; address/data hold when nothing is written.
    always_comb begin
        rf_we_d = 1'b0;
        rf_wa_d = rf_wa_q;
        rf_wd_d = rf_wd_q;
        if (pipe_win_c) begin
            rf_we_d = 1'b1;
            rf_wa_d = bus.pipe_wa;
            rf_wd_d = bus.pipe_wd;
        end else if (pop_c && (head_wa_c != RW'(0))) begin
            rf_we_d = 1'b1;
            rf_wa_d = head_wa_c;
            rf_wd_d = head_wd_c;
        end
    end

    // Pending scoreboard: clear on pop, set afterwards so a same-cycle set wins.
    always_comb begin
        pending_d = pending_q;
        if (pop_c) begin
            pending_d[head_wa_c] = 1'b0;
        end
        if (bus.sb_set) begin
            pending_d[bus.sb_set_addr] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    // Starvation counter, saturating at the limit.
    always_comb begin
        starve_d = starve_q;
        if (fifo_empty_c || pop_c) begin
            starve_d = SW'(0);
        end else if (starve_q < SW'(STARVE_LIMIT)) begin
            starve_d = starve_q + SW'(1);
        end
        stall_req_d = (starve_d >= SW'(STARVE_LIMIT));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            pending_q   <= '0;
            starve_q    <= '0;
            stall_req_q <= 1'b0;
            rf_we_q     <= 1'b0;
            rf_wa_q     <= '0;
            rf_wd_q     <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            pending_q   <= pending_d;
            starve_q    <= starve_d;
            stall_req_q <= stall_req_d;
            rf_we_q     <= rf_we_d;
            rf_wa_q     <= rf_wa_d;
            rf_wd_q     <= rf_wd_d;
        end
    end

    // Payload storage needs no reset: pointers and count gate every read.
    always_ff @(posedge clk) begin
        fifo_wa_q <= fifo_wa_d;
        fifo_wd_q <= fifo_wd_d;
    end

    assign bus.lu_ready   = lu_ready_c;
    assign bus.fifo_count = count_q;
    assign bus.stall_req  = stall_req_q;
    assign bus.rf_we      = rf_we_q;
    assign bus.rf_wa      = rf_wa_q;
    assign bus.rf_wd      = rf_wd_q;
    // The pop that feeds rf_w* has already cleared pending, so busy needs no extra term.
    assign bus.rs1_busy   = pending_q[bus.ra1];
    assign bus.rs2_busy   = pending_q[bus.ra2];

`ifdef WB_BYPASS_EN
    // Forward the write landing this edge so decode sees it before the RF does.
    always_comb begin
        bus.rd1_out = bus.rf_rd1;
        bus.rd2_out = bus.rf_rd2;
        if (rf_we_q && (rf_wa_q == bus.ra1) && (bus.ra1 != RW'(0))) begin
            bus.rd1_out = rf_wd_q;
        end
        if (rf_we_q && (rf_wa_q == bus.ra2) && (bus.ra2 != RW'(0))) begin
            bus.rd2_out = rf_wd_q;
        end
    end
`else
    assign bus.rd1_out = bus.rf_rd1;
    assign bus.rd2_out = bus.rf_rd2;
`endif

    // Decode must never issue a pipeline write over a register still pending.
    waw_over_pending_a: assert property (
        @(posedge clk) disable iff (!rst_n) !(pipe_win_c && pending_q[bus.pipe_wa])
    );

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed self-checking bench for wb_arbiter (FIFO_DEPTH=4, STARVE_LIMIT=8).
module tb_wb_arbiter;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    wb_arbiter_if #(.FIFO_DEPTH(4)) bus ();

    wb_arbiter #(.FIFO_DEPTH(4), .STARVE_LIMIT(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.pipe_we     = 1'b0;
        bus.pipe_wa     = 5'd0;
        bus.pipe_wd     = 32'd0;
        bus.lu_valid    = 1'b0;
        bus.lu_wa       = 5'd0;
        bus.lu_wd       = 32'd0;
        bus.sb_set      = 1'b0;
        bus.sb_set_addr = 5'd0;
        bus.ra1         = 5'd0;
        bus.ra2         = 5'd0;
        bus.rf_rd1      = 32'd0;
        bus.rf_rd2      = 32'd0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        #3;
        checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we got %b exp 0", bus.rf_we); end
        checks++; if (bus.rf_wa !== 5'd0) begin errors++; $display("FAIL reset_rf_wa got %0d exp 0", bus.rf_wa); end
        checks++; if (bus.rf_wd !== 32'd0) begin errors++; $display("FAIL reset_rf_wd got %h exp 0", bus.rf_wd); end
        checks++; if (bus.stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", bus.stall_req); end
        checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus.fifo_count); end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (bus.lu_ready !== 1'b1) begin errors++; $display("FAIL reset_lu_ready got %b exp 1", bus.lu_ready); end
        checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL idle_rf_we got %b exp 0", bus.rf_we); end
    endtask

    task automatic test_basic();
        bus.pipe_we = 1'b1; bus.pipe_wa = 5'd5; bus.pipe_wd = 32'hDEADBEEF;
        tick();
        checks++; if (bus.rf_we !== 1'b1) begin errors++; $display("FAIL pipe_rf_we got %b exp 1", bus.rf_we); end
        checks++; if (bus.rf_wa !== 5'd5) begin errors++; $display("FAIL pipe_rf_wa got %0d exp 5", bus.rf_wa); end
        checks++; if (bus.rf_wd !== 32'hDEADBEEF) begin errors++; $display("FAIL pipe_rf_wd got %h exp deadbeef", bus.rf_wd); end
        bus.pipe_wa = 5'd0; bus.pipe_wd = 32'h55;
        tick();
        bus.pipe_we = 1'b0;
        checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL pipe_x0_we got %b exp 0", bus.rf_we); end
        checks++; if (bus.rf_wd !== 32'hDEADBEEF) begin errors++; $display("FAIL pipe_x0_hold_wd got %h exp deadbeef", bus.rf_wd); end
        // FIFO entry targeting x0 is consumed without a write
        bus.lu_valid = 1'b1; bus.lu_wa = 5'd0; bus.lu_wd = 32'hBAD;
        tick();
        bus.lu_valid = 1'b0;
        checks++; if (bus.fifo_count !== 3'd1) begin errors++; $display("FAIL lu_x0_push_count got %0d exp 1", bus.fifo_count); end
        tick();
        checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL lu_x0_we got %b exp 0", bus.rf_we); end
        checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL lu_x0_pop_count got %0d exp 0", bus.fifo_count); end
        checks++; if (bus.rf_wa !== 5'd5) begin errors++; $display("FAIL lu_x0_hold_wa got %0d exp 5", bus.rf_wa); end
    endtask

    task automatic test_scoreboard();
        bus.sb_set = 1'b1; bus.sb_set_addr = 5'd7; bus.ra1 = 5'd7; bus.ra2 = 5'd0;
        tick();
        bus.sb_set = 1'b0;
        checks++; if (bus.rs1_busy !== 1'b1) begin errors++; $display("FAIL sb_set_busy got %b exp 1", bus.rs1_busy); end
        checks++; if (bus.rs2_busy !== 1'b0) begin errors++; $display("FAIL sb_x0_busy got %b exp 0", bus.rs2_busy); end
        bus.lu_valid = 1'b1; bus.lu_wa = 5'd7; bus.lu_wd = 32'h1234;
        tick();
        bus.lu_valid = 1'b0;
        checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL sb_no_fallthrough got %b exp 0", bus.rf_we); end
        checks++; if (bus.rs1_busy !== 1'b1) begin errors++; $display("FAIL sb_busy_queued got %b exp 1", bus.rs1_busy); end
        tick();
        checks++; if (bus.rf_we !== 1'b1) begin errors++; $display("FAIL sb_pop_we got %b exp 1", bus.rf_we); end
        checks++; if (bus.rf_wa !== 5'd7) begin errors++; $display("FAIL sb_pop_wa got %0d exp 7", bus.rf_wa); end
        checks++; if (bus.rf_wd !== 32'h1234) begin errors++; $display("FAIL sb_pop_wd got %h exp 1234", bus.rf_wd); end
        checks++; if (bus.rs1_busy !== 1'b0) begin errors++; $display("FAIL sb_clear_busy got %b exp 0", bus.rs1_busy); end
        // set coincident with the clearing pop keeps the register pending
        bus.sb_set = 1'b1; bus.sb_set_addr = 5'd7;
        tick();
        bus.sb_set = 1'b0;
        bus.lu_valid = 1'b1; bus.lu_wa = 5'd7; bus.lu_wd = 32'h5678;
        tick();
        bus.lu_valid = 1'b0;
        bus.sb_set = 1'b1; bus.sb_set_addr = 5'd7;
        tick();
        bus.sb_set = 1'b0;
        checks++; if (bus.rf_wd !== 32'h5678) begin errors++; $display("FAIL sb_set_win_wd got %h exp 5678", bus.rf_wd); end
        checks++; if (bus.rs1_busy !== 1'b1) begin errors++; $display("FAIL sb_set_wins got %b exp 1", bus.rs1_busy); end
        bus.lu_valid = 1'b1; bus.lu_wa = 5'd7; bus.lu_wd = 32'h9ABC;
        tick();
        bus.lu_valid = 1'b0;
        tick();
        checks++; if (bus.rf_wd !== 32'h9ABC) begin errors++; $display("FAIL sb_final_wd got %h exp 9abc", bus.rf_wd); end
        checks++; if (bus.rs1_busy !== 1'b0) begin errors++; $display("FAIL sb_final_busy got %b exp 0", bus.rs1_busy); end
        bus.ra1 = 5'd0;
    endtask

    task automatic test_fifo_full();
        bus.pipe_we = 1'b1; bus.pipe_wa = 5'd2;
        for (int i = 0; i < 5; i++) begin
            bus.pipe_wd  = 32'(i);
            bus.lu_valid = 1'b1;
            bus.lu_wa    = 5'(10 + i);
            bus.lu_wd    = 32'(32'h100 + i);
            #1;
            checks++; if (bus.lu_ready !== (i < 4)) begin errors++; $display("FAIL full_lu_ready[%0d] got %b exp %b", i, bus.lu_ready, (i < 4)); end
            tick();
        end
        bus.lu_valid = 1'b0;
        checks++; if (bus.fifo_count !== 3'd4) begin errors++; $display("FAIL full_count got %0d exp 4", bus.fifo_count); end
        checks++; if (bus.lu_ready !== 1'b0) begin errors++; $display("FAIL full_not_ready got %b exp 0", bus.lu_ready); end
        checks++; if (bus.rf_wd !== 32'd4 || bus.rf_wa !== 5'd2) begin errors++; $display("FAIL full_pipe_write got %0d/%h exp 2/4", bus.rf_wa, bus.rf_wd); end
        checks++; if (bus.stall_req !== 1'b0) begin errors++; $display("FAIL full_no_stall got %b exp 0", bus.stall_req); end
        bus.pipe_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (bus.rf_we !== 1'b1 || bus.rf_wa !== 5'(10 + i) || bus.rf_wd !== 32'(32'h100 + i)) begin
                errors++; $display("FAIL drain[%0d] got %b/%0d/%h exp 1/%0d/%h", i, bus.rf_we, bus.rf_wa, bus.rf_wd, 10 + i, 32'h100 + i);
            end
        end
        checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL drain_count got %0d exp 0", bus.fifo_count); end
    endtask

    task automatic test_starve();
        bus.pipe_we = 1'b1; bus.pipe_wa = 5'd3; bus.pipe_wd = 32'h0;
        bus.lu_valid = 1'b1; bus.lu_wa = 5'd12; bus.lu_wd = 32'hC0FFEE;
        tick();
        bus.lu_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            bus.pipe_wd = 32'(k);
            tick();
            checks++; if (bus.stall_req !== (k >= 8)) begin errors++; $display("FAIL starve[%0d] got %b exp %b", k, bus.stall_req, (k >= 8)); end
        end
        bus.pipe_we = 1'b0;
        tick();
        checks++; if (bus.rf_we !== 1'b1 || bus.rf_wa !== 5'd12 || bus.rf_wd !== 32'hC0FFEE) begin
            errors++; $display("FAIL starve_pop got %b/%0d/%h exp 1/12/c0ffee", bus.rf_we, bus.rf_wa, bus.rf_wd);
        end
        checks++; if (bus.stall_req !== 1'b0) begin errors++; $display("FAIL starve_release got %b exp 0", bus.stall_req); end
    endtask

    task automatic test_bypass();
        bus.pipe_we = 1'b1; bus.pipe_wa = 5'd3; bus.pipe_wd = 32'hAA;
        tick();
        bus.pipe_we = 1'b0;
        bus.ra1 = 5'd3; bus.rf_rd1 = 32'h11;
        bus.ra2 = 5'd3; bus.rf_rd2 = 32'h0;
        #1;
        checks++; if (bus.rd2_out !== (BYP ? 32'hAA : 32'h0)) begin errors++; $display("FAIL byp_rd2 got %h exp %h", bus.rd2_out, (BYP ? 32'hAA : 32'h0)); end
        checks++; if (bus.rd1_out !== (BYP ? 32'hAA : 32'h11)) begin errors++; $display("FAIL byp_rd1 got %h exp %h", bus.rd1_out, (BYP ? 32'hAA : 32'h11)); end
        bus.ra2 = 5'd4; bus.rf_rd2 = 32'h22;
        #1;
        checks++; if (bus.rd2_out !== 32'h22) begin errors++; $display("FAIL byp_other_reg got %h exp 22", bus.rd2_out); end
        tick();
        bus.ra2 = 5'd3; bus.rf_rd2 = 32'h33;
        #1;
        checks++; if (bus.rd2_out !== 32'h33) begin errors++; $display("FAIL byp_no_write got %h exp 33", bus.rd2_out); end
        drive_idle();
    endtask

    task automatic test_reset_mid();
        bus.pipe_we = 1'b1; bus.pipe_wa = 5'd4; bus.pipe_wd = 32'h44;
        bus.sb_set = 1'b1; bus.sb_set_addr = 5'd20; bus.ra1 = 5'd20;
        for (int i = 0; i < 3; i++) begin
            bus.lu_valid = 1'b1; bus.lu_wa = 5'(20 + i); bus.lu_wd = 32'(i);
            tick();
            bus.sb_set = 1'b0;
        end
        bus.lu_valid = 1'b0;
        checks++; if (bus.fifo_count !== 3'd3) begin errors++; $display("FAIL mid_count_pre got %0d exp 3", bus.fifo_count); end
        checks++; if (bus.rs1_busy !== 1'b1) begin errors++; $display("FAIL mid_busy_pre got %b exp 1", bus.rs1_busy); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL mid_rf_we got %b exp 0", bus.rf_we); end
        checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL mid_count got %0d exp 0", bus.fifo_count); end
        checks++; if (bus.lu_ready !== 1'b1) begin errors++; $display("FAIL mid_lu_ready got %b exp 1", bus.lu_ready); end
        checks++; if (bus.rs1_busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b exp 0", bus.rs1_busy); end
        checks++; if (bus.rf_wd !== 32'd0) begin errors++; $display("FAIL mid_rf_wd got %h exp 0", bus.rf_wd); end
        drive_idle();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        checks++; if (bus.rf_we !== 1'b0 || bus.fifo_count !== 3'd0) begin
            errors++; $display("FAIL mid_discard got %b/%0d exp 0/0", bus.rf_we, bus.fifo_count);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_scoreboard();
        test_fifo_full();
        test_starve();
        test_bypass();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback stage directly upstream of the register file; sole driver of its single write port (we/wa/wd).
- Merges two result sources into that port: the in-order pipeline writeback, and a long-latency unit (load/divide) that uses a valid/ready handshake.
- Long-unit results wait in a small FIFO.
- A per-register pending scoreboard tells decode which source registers still await a long-unit result.

Parameters:
- FIFO_DEPTH, 4, entries in long-unit result buffer (power of 2, >=2)
- STARVE_LIMIT, 8, consecutive blocked cycles before stall_req asserts (>=1)

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- pipe_we  input  1  pipeline writeback valid
- pipe_wa  input  5  pipeline destination register
- pipe_wd  input  32  pipeline writeback data
- lu_valid  input  1  long-unit result valid
- lu_ready  output  1  FIFO can accept (not full)
- lu_wa  input  5  long-unit destination register
- lu_wd  input  32  long-unit result data
- sb_set  input  1  decode issued a long op this cycle
- sb_set_addr  input  5  its destination register
- ra1, ra2  input  5  decode source addresses (same as register-file read addresses)
- rs1_busy, rs2_busy  output  1  source register has a pending long-unit result
- rf_rd1, rf_rd2  input  32  register-file read data
- rd1_out, rd2_out  output  32  operand data to execute
- rf_we  output  1  register-file write enable
- rf_wa  output  5  register-file write address
- rf_wd  output  32  register-file write data
- stall_req  output  1  asks pipeline to bubble writeback next cycle
- fifo_count  output  $clog2(FIFO_DEPTH)+1  occupancy, debug

Behaviour:
- Reset is asynchronous. While rst_n=0, all of the following are 0:
  - rf_we, rf_wa, rf_wd, stall_req
  - FIFO pointers and fifo_count
  - scoreboard, starve counter
- lu_ready is 1 once out of reset with an empty FIFO.
- A reset during an operation discards all buffered results and pending bits.
- Writes to register 0:
  - pipe_we with pipe_wa=0 is treated as idle.
  - A FIFO entry with wa=0 is popped but not written (rf_we stays 0).
  - sb_set with address 0 is ignored.
- FIFO push: on lu_valid && lu_ready. lu_ready = (count != FIFO_DEPTH) and is combinational from count only.
- Push and pop in the same cycle:
  - Count is unchanged.
  - Allowed when full only if a pop occurs; lu_ready still reads 0 when full, so no push happens while full.
- Arbitration, each cycle:
  - If pipe_we && pipe_wa!=0: the pipeline wins.
  - Else, if the FIFO is non-empty: pop the head.
  - Pipeline writeback is never stalled or dropped.
- Output register: rf_we/rf_wa/rf_wd are registered, giving 1-cycle latency from the winning input to the register-file port.
  - An idle cycle gives rf_we=0; rf_wa/rf_wd hold their last values.
- An empty-FIFO push becomes eligible for pop the following cycle (no same-cycle fall-through).
- Scoreboard: 32 pending bits, bit 0 hardwired to 0.
  - Set on sb_set.
  - Cleared when a FIFO entry for that register is popped.
  - Simultaneous set and clear of the same register: set wins.
  - A pipeline write does not clear a pending bit. Decode must not issue WAW over a pending register (checked by assertion).
- rs1_busy = pending[ra1], rs2_busy = pending[ra2]; both combinational.
- Starve counter:
  - Increments each cycle the FIFO is non-empty and the pipeline wins.
  - Resets to 0 on any pop or when the FIFO is empty.
  - stall_req = (counter >= STARVE_LIMIT), registered.
  - The pipeline answers stall_req by presenting pipe_we=0 the next cycle. The pop then resets the counter and deasserts stall_req.

Optional Feature:
- Macro: WB_BYPASS_EN.
- When defined:
  - rd1_out = rf_wd if (rf_we && rf_wa==ra1 && ra1!=0), else rf_rd1. rd2_out is the same with ra2.
  - This covers the write landing on the current edge.
  - rs1_busy/rs2_busy additionally go to 0 when the popped entry (registered into rf_w*) matches, since the scoreboard clears on that pop.
- When not defined: rd1_out = rf_rd1, rd2_out = rf_rd2 (pure pass-through); ports are unchanged.

Test Plan:
1. Reset then idle:
   - rst_n low mid-traffic with 3 FIFO entries -> rf_we=0, fifo_count=0, lu_ready=1, all busy=0 immediately, without waiting for a clock edge.
2. Basic paths:
   - pipe_we=1, wa=5, wd=0xDEADBEEF at cycle N -> rf_we=1, rf_wa=5, rf_wd=0xDEADBEEF at N+1.
   - pipe_wa=0 -> rf_we stays 0.
3. Scoreboard:
   - sb_set addr=7; ra1=7 -> rs1_busy=1.
   - lu pushes wa=7, wd=0x1234 with pipe idle -> popped next cycle, rf_w* = 7/0x1234 the cycle after, rs1_busy=0.
   - sb_set addr=7 coincident with that pop -> busy stays 1.
4. FIFO full:
   - FIFO_DEPTH=4, pipe_we=1 continuously, 5 lu results offered -> 4 accepted, lu_ready=0, fifo_count=4.
   - Then pipe idle -> 4 writes drained in order, one per cycle.
5. Starvation:
   - STARVE_LIMIT=8, 1 FIFO entry, pipe_we=1 every cycle -> stall_req rises after 8 blocked cycles.
   - Pipe bubble -> entry written, stall_req falls.
6. Bypass (WB_BYPASS_EN on):
   - rf_we=1, rf_wa=3, rf_wd=0xAA with ra2=3, rf_rd2=0x0 -> rd2_out=0xAA.
   - Macro off -> rd2_out=0x0.
